// File: rtl/line_buf_win.sv
// Chained circular line buffers producing a (CH+1)-tap vertical window.
// Fill tracking zero-masks history so stale storage never reaches the outputs.
module line_buf_win #(
   parameter int WL      = 8,
   parameter int MAX_LEN = 17,
   parameter int CH      = 2,
   parameter int LW      = 5
) (
   input  logic                   iCLK,
   input  logic                   iRST_N,
   input  logic                   iEN,
   input  logic                   iSTART,
   input  logic [LW-1:0]          iLEN,
   input  logic [WL-1:0]          iDATA,
   output logic [WL*(CH+1)-1:0]   oDATA,
   output logic                   oEN,
   output logic                   oVALID
);

   localparam int PW   = $clog2(MAX_LEN);
   localparam int LENW = $clog2(MAX_LEN + 1);
   localparam int FW   = $clog2(CH * MAX_LEN + 1);
   localparam logic [LENW-1:0] MAX_L = LENW'(MAX_LEN);

   logic [WL-1:0]          mem [CH][MAX_LEN];
   logic [WL-1:0]          rdData_s [CH];

   logic [PW-1:0]          ptr_r, ptrNext_s;
   logic [LENW-1:0]        len_r, lenNext_s, lenSel_s;
   logic [FW-1:0]          fill_r, fillNext_s, fullLen_s;
   logic [WL*(CH+1)-1:0]   data_r, dataNext_s;
   logic                   en_r, enNext_s;
   logic                   valid_r, validNext_s;
   logic                   wrEn_s;

   assign oDATA  = data_r;
   assign oEN    = en_r;
   assign oVALID = valid_r;

   // Next-state for pointer, fill counter, length and output taps
   always_comb begin
      ptrNext_s   = ptr_r;
      lenNext_s   = len_r;
      fillNext_s  = fill_r;
      dataNext_s  = data_r;
      enNext_s    = 1'b0;
      validNext_s = valid_r;
      wrEn_s      = 1'b0;
      fullLen_s   = FW'(CH) * FW'(len_r);
      for (int k = 0; k < CH; k++) begin
         rdData_s[k] = mem[k][ptr_r];
      end
      if ((iLEN == {LW{1'b0}}) || (iLEN > LW'(MAX_LEN))) begin
         lenSel_s = MAX_L;
      end else begin
         lenSel_s = LENW'(iLEN);
      end

      if (iSTART) begin
         ptrNext_s   = {PW{1'b0}};
         lenNext_s   = lenSel_s;
         fillNext_s  = {FW{1'b0}};
         dataNext_s  = {(WL*(CH+1)){1'b0}};
         validNext_s = 1'b0;
      end else if (iEN) begin
         wrEn_s   = 1'b1;
         enNext_s = 1'b1;
         if (LENW'(ptr_r) == (len_r - LENW'(1))) begin
            ptrNext_s = {PW{1'b0}};
         end else begin
            ptrNext_s = ptr_r + PW'(1);
         end
         if (fill_r < fullLen_s) begin
            fillNext_s = fill_r + FW'(1);
         end else begin
            fillNext_s = fill_r;
         end
         validNext_s = valid_r | ((fill_r + FW'(1)) == fullLen_s);
         dataNext_s[WL-1:0] = iDATA;
         // tap k stays zero until k*L samples of real history exist
         for (int k = 1; k <= CH; k++) begin
            if (fill_r < (FW'(k) * FW'(len_r))) begin
               dataNext_s[WL*k +: WL] = {WL{1'b0}};
            end else begin
               dataNext_s[WL*k +: WL] = rdData_s[k-1];
            end
         end
      end else begin
         enNext_s = 1'b0;
      end
   end

   // Control and output registers with synchronous active-low reset
   always_ff @(posedge iCLK) begin
      if (!iRST_N) begin
         ptr_r   <= {PW{1'b0}};
         len_r   <= MAX_L;
         fill_r  <= {FW{1'b0}};
         data_r  <= {(WL*(CH+1)){1'b0}};
         en_r    <= 1'b0;
         valid_r <= 1'b0;
      end else begin
         ptr_r   <= ptrNext_s;
         len_r   <= lenNext_s;
         fill_r  <= fillNext_s;
         data_r  <= dataNext_s;
         en_r    <= enNext_s;
         valid_r <= validNext_s;
      end
   end

   // Storage: read-before-write at the shared pointer, each line feeds the next
   always_ff @(posedge iCLK) begin
      if (iRST_N && wrEn_s) begin
         mem[0][ptr_r] <= iDATA;
         for (int k = 1; k < CH; k++) begin
            mem[k][ptr_r] <= rdData_s[k-1];
         end
      end
   end

endmodule

// File: tb/tb_line_buf_win.sv
// Randomised bench for line_buf_win against a sample-history reference model.
module tb_line_buf_win;

   localparam int WL = 8, MAX_LEN = 17, CH = 2, LW = 5;

   logic                  iCLK = 1'b0;
   logic                  iRST_N, iEN, iSTART;
   logic [LW-1:0]         iLEN;
   logic [WL-1:0]         iDATA;
   logic [WL*(CH+1)-1:0]  oDATA;
   logic                  oEN, oVALID;

   int passCnt = 0, totalCnt = 0;

   int                    lMod = MAX_LEN;
   int                    nAcc = 0;
   logic [WL-1:0]         hist[$];
   logic [WL*(CH+1)-1:0]  expData = '0;
   logic                  expEn = 1'b0, expValid = 1'b0;
   logic [WL-1:0]         seq = 8'd0;

   line_buf_win #(.WL(WL), .MAX_LEN(MAX_LEN), .CH(CH), .LW(LW)) dut (
      .iCLK(iCLK), .iRST_N(iRST_N), .iEN(iEN), .iSTART(iSTART),
      .iLEN(iLEN), .iDATA(iDATA), .oDATA(oDATA), .oEN(oEN), .oVALID(oVALID)
   );

   always #5 iCLK = ~iCLK;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      totalCnt++;
      if (obs !== exp) begin
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
      end else begin
         passCnt++;
      end
   endtask

   // Reference: tap k after the n-th accepted sample is sample n-k*L, or 0 if none
   task automatic modelUpdate(input logic rstN, input logic st, input logic en,
                              input logic [LW-1:0] len, input logic [WL-1:0] d);
      if (!rstN) begin
         lMod = MAX_LEN; nAcc = 0; hist.delete();
         expData = '0; expEn = 1'b0; expValid = 1'b0;
      end else if (st) begin
         lMod = (len == 0 || int'(len) > MAX_LEN) ? MAX_LEN : int'(len);
         nAcc = 0; hist.delete();
         expData = '0; expEn = 1'b0; expValid = 1'b0;
      end else if (en) begin
         hist.push_back(d);
         nAcc++;
         expData[WL-1:0] = d;
         for (int k = 1; k <= CH; k++) begin
            expData[WL*k +: WL] = (nAcc > k * lMod) ? hist[nAcc - 1 - k * lMod] : '0;
         end
         expEn = 1'b1;
         expValid = (nAcc >= CH * lMod);
      end else begin
         expEn = 1'b0;
      end
   endtask

   task automatic step(input logic rstN, input logic st, input logic en,
                       input logic [LW-1:0] len, input logic [WL-1:0] d);
      iRST_N = rstN; iSTART = st; iEN = en; iLEN = len; iDATA = d;
      @(posedge iCLK);
      modelUpdate(rstN, st, en, len, d);
      #1;
      chk("oDATA", 64'(oDATA), 64'(expData));
      chk("oEN", 64'(oEN), 64'(expEn));
      chk("oVALID", 64'(oVALID), 64'(expValid));
   endtask

   task automatic stream(input int n);
      for (int i = 0; i < n; i++) begin
         seq = seq + 8'd1;
         step(1'b1, 1'b0, 1'b1, LW'($urandom_range(0, 31)), seq);
      end
   endtask

   initial begin
      #1;
      step(1'b0, 1'b0, 1'b1, 5'd3, 8'h55);
      step(1'b0, 1'b1, 1'b1, 5'd3, 8'h66);
      // power-up stream 1..40 at L=17
      seq = 8'd0; stream(40);
      // L=4, stream 1..20
      step(1'b1, 1'b1, 1'b0, 5'd4, 8'h00);
      seq = 8'd0; stream(20);
      // out-of-range lengths behave as MAX_LEN
      step(1'b1, 1'b1, 1'b0, 5'd0, 8'h00);
      seq = 8'd0; stream(40);
      step(1'b1, 1'b1, 1'b0, 5'd31, 8'h00);
      seq = 8'd0; stream(40);
      // L=4 with irregular enable
      step(1'b1, 1'b1, 1'b0, 5'd4, 8'h00);
      for (int i = 0; i < 60; i++) begin
         seq = seq + 8'd1;
         step(1'b1, 1'b0, 1'($urandom_range(0, 1)), LW'($urandom), seq);
      end
      // restart together with iEN drops that sample
      step(1'b1, 1'b1, 1'b1, 5'd4, 8'hAA);
      seq = 8'd0; stream(12);
      // one-cycle reset mid-stream then refill from zero
      step(1'b0, 1'b0, 1'b1, 5'd4, 8'h77);
      seq = 8'd0; stream(40);
      // random mix of all controls
      for (int i = 0; i < 3000; i++) begin
         seq = seq + 8'd1;
         step(($urandom_range(0, 199) != 0),
              ($urandom_range(0, 59) == 0),
              ($urandom_range(0, 9) < 7),
              LW'($urandom_range(0, 31)),
              8'($urandom));
      end
      $display("%0d/%0d checks passed", passCnt, totalCnt);
      $finish;
   end

endmodule
